// File: rtl/power_analyzer_pkg.sv
// Shared types and helpers for the power-analyser capture path.
package power_analyzer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        CAPTURE,
        DONE
    } cap_state_t;

    localparam int NUM_CH_DEF   = 6;
    localparam int SAMPLE_W_DEF = 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/adc_serial_rx.sv
// Shared SCLK/CS_N generator for a bank of serial ADCs plus one MSB-first
// deserialiser per channel; frame_end strobes in the cycle whose edge raises CS_N.
module adc_serial_rx
    import power_analyzer_pkg::*;
#(
    parameter int NUM_CH     = NUM_CH_DEF,
    parameter int SAMPLE_W   = SAMPLE_W_DEF,
    parameter int LEAD_BITS  = 3,
    parameter int FRAME_BITS = 16,
    parameter int SCLK_DIV   = 25
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            adc_sdata,
    output logic                         adc_sclk,
    output logic                         adc_cs_n,
    output logic                         frame_end,
    output logic [NUM_CH*SAMPLE_W-1:0]   frame_data
);

    localparam int HALVES = 2 * (FRAME_BITS + 1);
    localparam int HALF_W = clog2(HALVES);
    localparam int DIV_W  = (SCLK_DIV > 1) ? clog2(SCLK_DIV) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(SCLK_DIV - 1);
    localparam logic [HALF_W-1:0] LAST_HALF  = HALF_W'(HALVES - 1);
    localparam logic [HALF_W-1:0] CS_HALVES  = HALF_W'(2 * FRAME_BITS);
    localparam logic [HALF_W-1:0] END_HALF   = HALF_W'(2 * FRAME_BITS - 1);
    localparam logic [HALF_W-1:0] FIRST_DATA = HALF_W'(2 * LEAD_BITS);
    localparam logic [HALF_W-1:0] LAST_DATA  = HALF_W'(2 * (LEAD_BITS + SAMPLE_W - 1));

    logic [DIV_W-1:0]                  div_cnt;
    logic [HALF_W-1:0]                 half_cnt;
    logic [HALF_W-1:0]                 half_nxt;
    logic                              tick;
    logic                              shift_en;
    logic [NUM_CH-1:0][SAMPLE_W-1:0]   shreg;

    assign tick      = (div_cnt == DIV_LAST);
    assign half_nxt  = (half_cnt == LAST_HALF) ? '0 : half_cnt + 1'b1;
    assign frame_end = tick && (half_cnt == END_HALF);

    // Even halves are SCLK-low; the tick leaving one is the edge that raises SCLK.
    assign shift_en  = tick && !half_cnt[0] &&
                       (half_cnt >= FIRST_DATA) && (half_cnt <= LAST_DATA);

    // Reset parks the counters at the end of the CS-high gap so the first
    // edge after release opens a frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt  <= DIV_LAST;
            half_cnt <= LAST_HALF;
            adc_sclk <= 1'b1;
            adc_cs_n <= 1'b1;
        end else if (tick) begin
            div_cnt  <= '0;
            half_cnt <= half_nxt;
            adc_cs_n <= (half_nxt >= CS_HALVES);
            adc_sclk <= (half_nxt >= CS_HALVES) || half_nxt[0];
        end else begin
            div_cnt  <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (shift_en) begin
            for (int k = 0; k < NUM_CH; k++) begin
                shreg[k] <= (shreg[k] << 1) | SAMPLE_W'(adc_sdata[k]);
            end
        end
    end

    assign frame_data = shreg;

endmodule

// File: rtl/multichannel_sample_capture.sv
// N-channel serial-ADC capture: live frame feed plus DEPTH-frame snapshot RAM.
// Optional macro ZERO_CROSS_TRIG_EN gates capture start on a ch0 upward midscale crossing.
module multichannel_sample_capture
    import power_analyzer_pkg::*;
#(
    parameter int  NUM_CH     = NUM_CH_DEF,
    parameter int  SAMPLE_W   = SAMPLE_W_DEF,
    parameter int  LEAD_BITS  = 3,
    parameter int  FRAME_BITS = 16,
    parameter int  SCLK_DIV   = 25,
    parameter int  DEPTH      = 4096,
    localparam int ADDR_W     = clog2(DEPTH),
    localparam int CH_W       = (NUM_CH > 1) ? clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         adc_sclk,
    output logic                         adc_cs_n,
    input  logic [NUM_CH-1:0]            adc_sdata,
    input  logic                         take_sample,
    output logic                         busy,
    output logic                         done,
    input  logic [ADDR_W-1:0]            rd_addr,
    input  logic [CH_W-1:0]              rd_ch,
    output logic [SAMPLE_W-1:0]          rd_data,
    output logic [NUM_CH*SAMPLE_W-1:0]   live_data,
    output logic                         live_valid
);

    logic                              frame_end;
    logic [NUM_CH*SAMPLE_W-1:0]        frame_data;
    cap_state_t                        state;
    logic [ADDR_W-1:0]                 ptr;
    logic                              take_prev;
    logic                              take_edge;
    logic                              wr_en;
    logic [NUM_CH-1:0][SAMPLE_W-1:0]   mem [DEPTH];

    adc_serial_rx #(
        .NUM_CH     (NUM_CH),
        .SAMPLE_W   (SAMPLE_W),
        .LEAD_BITS  (LEAD_BITS),
        .FRAME_BITS (FRAME_BITS),
        .SCLK_DIV   (SCLK_DIV)
    ) u_rx (
        .clk        (clk),
        .reset      (reset),
        .adc_sdata  (adc_sdata),
        .adc_sclk   (adc_sclk),
        .adc_cs_n   (adc_cs_n),
        .frame_end  (frame_end),
        .frame_data (frame_data)
    );

    assign take_edge = take_sample & ~take_prev;

`ifdef ZERO_CROSS_TRIG_EN
    localparam logic [SAMPLE_W-1:0] MIDSCALE = SAMPLE_W'(1) << (SAMPLE_W - 1);
    logic cross;

    // live_data still holds the previous frame while frame_data carries the new one.
    assign cross = (live_data[SAMPLE_W-1:0] < MIDSCALE) &&
                   (frame_data[SAMPLE_W-1:0] >= MIDSCALE);
    assign wr_en = frame_end &&
                   ((state == CAPTURE) || ((state == ARM) && take_sample && cross));
`else
    assign wr_en = frame_end && (state == CAPTURE);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ptr       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            take_prev <= 1'b0;
        end else begin
            take_prev <= take_sample;
            case (state)
                IDLE, DONE: begin
                    if (take_edge) begin
                        state <= ARM;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                ARM: begin
`ifdef ZERO_CROSS_TRIG_EN
                    if (!take_sample) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (frame_end && cross) begin
                        state <= CAPTURE;
                        ptr   <= ptr + 1'b1;
                    end
`else
                    if (frame_end) state <= CAPTURE;
`endif
                end
                CAPTURE: begin
                    if (frame_end) begin
                        ptr <= ptr + 1'b1;
                        if (ptr == ADDR_W'(DEPTH - 1)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            live_data  <= '0;
            live_valid <= 1'b0;
        end else begin
            live_valid <= frame_end;
            if (frame_end) live_data <= frame_data;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[ptr] <= frame_data;
    end

    // Registered read; a same-cycle write to the same address is seen next read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (int'(rd_ch) < NUM_CH) begin
            rd_data <= mem[rd_addr][rd_ch];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_multichannel_sample_capture.sv
// Self-checking bench: serial ADC model feeds a frame history queue that serves
// as the reference for live output and capture RAM contents.
module tb_multichannel_sample_capture;

    localparam int NUM_CH = 6;
    localparam int SW     = 8;
    localparam int LEAD   = 3;
    localparam int FB     = 16;
    localparam int SDIV   = 2;
    localparam int DEPTH  = 16;
    localparam int PERIOD = (FB + 1) * 2 * SDIV;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              take_sample = 1'b0;
    logic [NUM_CH-1:0] adc_sdata = '0;
    logic [3:0]        rd_addr = '0;
    logic [2:0]        rd_ch = '0;
    logic              adc_sclk, adc_cs_n, busy, done, live_valid;
    logic [SW-1:0]     rd_data;
    logic [NUM_CH*SW-1:0] live_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [SW-1:0]        cur_val [NUM_CH];
    logic [NUM_CH*SW-1:0] hist [$];
    logic [NUM_CH*SW-1:0] exp_mem [DEPTH];
    int                   bitcnt = 0;
    int                   mode = 0;

    multichannel_sample_capture #(
        .NUM_CH(NUM_CH), .SAMPLE_W(SW), .LEAD_BITS(LEAD), .FRAME_BITS(FB),
        .SCLK_DIV(SDIV), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .adc_sclk(adc_sclk), .adc_cs_n(adc_cs_n),
        .adc_sdata(adc_sdata), .take_sample(take_sample), .busy(busy), .done(done),
        .rd_addr(rd_addr), .rd_ch(rd_ch), .rd_data(rd_data),
        .live_data(live_data), .live_valid(live_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [NUM_CH*SW-1:0] pack_cur();
        logic [NUM_CH*SW-1:0] f;
        for (int k = 0; k < NUM_CH; k++) f[k*SW +: SW] = cur_val[k];
        return f;
    endfunction

    function automatic logic [SW-1:0] ch_of(input logic [NUM_CH*SW-1:0] f, input int k);
        return f[k*SW +: SW];
    endfunction

    // ADC model: bit n of a frame is presented on the n-th SCLK fall; lead and
    // trailing bits carry random junk the receiver must ignore.
    always @(negedge adc_sclk) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (bitcnt >= LEAD && bitcnt < LEAD + SW)
                adc_sdata[k] = cur_val[k][SW-1-(bitcnt-LEAD)];
            else
                adc_sdata[k] = 1'($urandom);
        end
        bitcnt++;
    end

    always @(posedge adc_cs_n) begin
        hist.push_back(pack_cur());
        bitcnt = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            case (mode)
                0: cur_val[k] = cur_val[k] + 8'd1;
                2: cur_val[k] = (k == 0) ? ((cur_val[0] >= 8'h8E) ? 8'h70 : cur_val[0] + 8'd3)
                                         : 8'($urandom);
                3: cur_val[k] = (k == 0) ? 8'h10 : 8'($urandom);
                default: cur_val[k] = 8'($urandom);
            endcase
        end
    end

    task automatic wait_frame(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!live_valid && cyc < 300);
        if (!live_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_timeout: no live_valid within %0d cycles", cyc);
        end
    endtask

    task automatic read_ram(input int a, input int c, output logic [SW-1:0] v);
        @(negedge clk);
        rd_addr = 4'(a);
        rd_ch   = 3'(c);
        @(negedge clk);
        v = rd_data;
    endtask

    task automatic test_reset();
        int cyc;
        reset = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if ({adc_sclk, adc_cs_n, busy, done, live_valid} !== 5'b11000) begin
            n_fail++;
            $display("FAIL reset_ctrl: sclk,cs_n,busy,done,valid got %b expected 11000",
                     {adc_sclk, adc_cs_n, busy, done, live_valid});
        end
        n_checks++;
        if (rd_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_rd_data: got %h expected 00", rd_data);
        end
        n_checks++;
        if (live_data !== '0) begin
            n_fail++;
            $display("FAIL reset_live_data: got %h expected 0", live_data);
        end
        for (int k = 0; k < NUM_CH; k++) cur_val[k] = 8'h10 + 8'(k);
        mode   = 0;
        bitcnt = 0;
        reset  = 1'b1;
        @(negedge clk);
        n_checks++;
        if (adc_cs_n !== 1'b0 || adc_sclk !== 1'b0) begin
            n_fail++;
            $display("FAIL first_cs_fall: cs_n=%b sclk=%b expected 0 0", adc_cs_n, adc_sclk);
        end
        wait_frame(cyc);
        n_checks++;
        if (live_data !== 48'h15_14_13_12_11_10) begin
            n_fail++;
            $display("FAIL first_frame: got %h expected 151413121110", live_data);
        end
        wait_frame(cyc);
        n_checks++;
        if (cyc != PERIOD) begin
            n_fail++;
            $display("FAIL frame_period: got %0d expected %0d", cyc, PERIOD);
        end
    endtask

    task automatic test_live();
        int cyc;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) mode = 1;
            wait_frame(cyc);
            n_checks++;
            if (live_data !== hist[$]) begin
                n_fail++;
                $display("FAIL live_data[%0d]: got %h expected %h", i, live_data, hist[$]);
            end
            n_checks++;
            if (cyc != PERIOD) begin
                n_fail++;
                $display("FAIL live_period[%0d]: got %0d expected %0d", i, cyc, PERIOD);
            end
        end
    endtask

    task automatic test_capture();
        int cyc, s;
        logic [SW-1:0] v, e;
        mode = 0;
        wait_frame(cyc);
        s = hist.size();
        take_sample = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL arm_busy: busy=%b done=%b expected 1 0", busy, done);
        end
        for (int f = 1; f <= DEPTH + 1; f++) begin
            wait_frame(cyc);
            if (f == DEPTH) begin
                n_checks++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL done_early: busy=%b done=%b expected 1 0", busy, done);
                end
            end
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_flag: busy=%b done=%b expected 0 1", busy, done);
        end
        take_sample = 1'b0;
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = hist[s + 1 + i];
        for (int i = 0; i < DEPTH; i++) begin
            for (int k = 0; k < 8; k++) begin
                read_ram(i, k, v);
                e = (k < NUM_CH) ? ch_of(exp_mem[i], k) : 8'h00;
                n_checks++;
                if (v !== e) begin
                    n_fail++;
                    $display("FAIL cap_read[%0d][%0d]: got %h expected %h", i, k, v, e);
                end
            end
        end
    endtask

    task automatic test_ignore_retrigger();
        int cyc, s;
        logic [SW-1:0] v;
        mode = 1;
        wait_frame(cyc);
        s = hist.size();
        take_sample = 1'b1;
        repeat (3) @(negedge clk);
        take_sample = 1'b0;
        for (int f = 1; f <= DEPTH + 1; f++) begin
            wait_frame(cyc);
            if (f == 6) begin
                take_sample = 1'b1;
                repeat (3) @(negedge clk);
                take_sample = 1'b0;
            end
            if (f == DEPTH) begin
                n_checks++;
                if (done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL retrig_done_early: done=%b expected 0", done);
                end
            end
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL retrig_done: busy=%b done=%b expected 0 1", busy, done);
        end
        repeat (3) wait_frame(cyc);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_hold: busy=%b done=%b expected 0 1", busy, done);
        end
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = hist[s + 1 + i];
        for (int i = 0; i < DEPTH; i++) begin
            for (int k = 0; k < NUM_CH; k++) begin
                read_ram(i, k, v);
                n_checks++;
                if (v !== ch_of(exp_mem[i], k)) begin
                    n_fail++;
                    $display("FAIL retrig_read[%0d][%0d]: got %h expected %h",
                             i, k, v, ch_of(exp_mem[i], k));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int cyc, s;
        mode = 1;
        wait_frame(cyc);
        s = hist.size();
        take_sample = 1'b1;
        @(negedge clk);
        take_sample = 1'b0;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rearm_clear: busy=%b done=%b expected 1 0", busy, done);
        end
        wait_frame(cyc);
        repeat (PERIOD - 1) @(negedge clk);
        rd_addr = 4'd0;
        rd_ch   = 3'd2;
        @(negedge clk);
        n_checks++;
        if (live_valid !== 1'b1 || rd_data !== ch_of(exp_mem[0], 2)) begin
            n_fail++;
            $display("FAIL rw_collision_old: valid=%b got %h expected %h",
                     live_valid, rd_data, ch_of(exp_mem[0], 2));
        end
        @(negedge clk);
        n_checks++;
        if (rd_data !== ch_of(hist[s + 1], 2)) begin
            n_fail++;
            $display("FAIL rw_collision_new: got %h expected %h", rd_data, ch_of(hist[s + 1], 2));
        end
        for (int f = 3; f <= DEPTH + 1; f++) wait_frame(cyc);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_done: busy=%b done=%b expected 0 1", busy, done);
        end
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = hist[s + 1 + i];
    endtask

    task automatic test_reset_mid();
        int cyc, s;
        logic [SW-1:0] v;
        mode = 1;
        wait_frame(cyc);
        take_sample = 1'b1;
        @(negedge clk);
        take_sample = 1'b0;
        repeat (9) wait_frame(cyc);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, done, adc_cs_n, adc_sclk, live_valid} !== 5'b00110 || live_data !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: busy,done,cs_n,sclk,valid got %b expected 00110 live=%h",
                     {busy, done, adc_cs_n, adc_sclk, live_valid}, live_data);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        wait_frame(cyc);
        wait_frame(cyc);
        n_checks++;
        if (live_data !== hist[$] || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_live: got %h expected %h busy=%b", live_data, hist[$], busy);
        end
        s = hist.size();
        take_sample = 1'b1;
        @(negedge clk);
        take_sample = 1'b0;
        for (int f = 1; f <= DEPTH + 1; f++) wait_frame(cyc);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_done: busy=%b done=%b expected 0 1", busy, done);
        end
        for (int i = 0; i < DEPTH; i++) begin
            for (int k = 0; k < NUM_CH; k++) begin
                read_ram(i, k, v);
                n_checks++;
                if (v !== ch_of(hist[s + 1 + i], k)) begin
                    n_fail++;
                    $display("FAIL post_reset_read[%0d][%0d]: got %h expected %h",
                             i, k, v, ch_of(hist[s + 1 + i], k));
                end
            end
        end
    endtask

`ifdef ZERO_CROSS_TRIG_EN
    task automatic test_zero_cross();
        int cyc, s, j, n;
        logic [SW-1:0] v;
        wait_frame(cyc);
        mode = 2;
        cur_val[0] = 8'h70;
        s = hist.size();
        take_sample = 1'b1;
        n = 0;
        do begin
            wait_frame(cyc);
            n++;
        end while (done !== 1'b1 && n < 60);
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL zc_done: done=%b expected 1 after %0d frames", done, n);
        end
        take_sample = 1'b0;
        j = s;
        while (j < hist.size() - 1 &&
               !(ch_of(hist[j-1], 0) < 8'h80 && ch_of(hist[j], 0) >= 8'h80)) j++;
        for (int i = 0; i < DEPTH; i++) begin
            for (int k = 0; k < 2; k++) begin
                read_ram(i, k, v);
                n_checks++;
                if (v !== ch_of(hist[j + i], k)) begin
                    n_fail++;
                    $display("FAIL zc_read[%0d][%0d]: got %h expected %h",
                             i, k, v, ch_of(hist[j + i], k));
                end
            end
        end
        wait_frame(cyc);
        mode = 3;
        cur_val[0] = 8'h10;
        take_sample = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL zc_arm: busy=%b done=%b expected 1 0", busy, done);
        end
        repeat (5) @(negedge clk);
        take_sample = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL zc_abort: busy=%b done=%b expected 0 0", busy, done);
        end
        repeat (2) wait_frame(cyc);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zc_idle_hold: busy=%b expected 0", busy);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_live();
        test_capture();
        test_ignore_retrigger();
        test_back_to_back();
        test_reset_mid();
`ifdef ZERO_CROSS_TRIG_EN
        test_zero_cross();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
